// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher.
// Expands the full key schedule first (one round key per cycle), then runs the
// inverse rounds from rk[10] down to rk[0]. Byte 0 is bits [127:120], column-major.
module aes_inv_core (
    input  logic         int_osc,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {StIdle, StKeyExp, StInitAk, StRound, StFinal, StDone} state_e;

    // GF(2^8) arithmetic, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
                 ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // Row r rotated right by r: out[r][c] = in[r][c - r].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Forward schedule step: RotWord, SubWord, Rcon on the last word, then chain.
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e       r_state;
    state_e       w_state_nxt;
    logic [3:0]   r_rnd;
    logic [127:0] r_st;
    logic [127:0] r_pt;
    logic [127:0] r_rk [0:10];

    logic [127:0] w_shift;
    logic [127:0] w_sub;
    logic [127:0] w_rk_next;

    assign w_shift   = inv_shift_rows(r_st);
    assign w_sub     = inv_sub_bytes(w_shift);
    assign w_rk_next = key_expand(r_rk[r_rnd - 4'd1], rcon(r_rnd));
    assign plaintext = r_pt;

    // State register.
    always_ff @(posedge int_osc) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            StIdle:   if (load) w_state_nxt = StKeyExp;
            StKeyExp: begin
                busy = 1'b1;
                if (r_rnd == 4'd10) w_state_nxt = StInitAk;
            end
            StInitAk: begin
                busy        = 1'b1;
                w_state_nxt = StRound;
            end
            StRound: begin
                busy = 1'b1;
                if (r_rnd == 4'd1) w_state_nxt = StFinal;
            end
            StFinal: begin
                busy        = 1'b1;
                w_state_nxt = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (load) w_state_nxt = StKeyExp;
            end
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Datapath: key file, round counter, cipher state and result register.
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            r_rnd <= '0;
            r_st  <= '0;
            r_pt  <= '0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (load) begin
                        r_rk[0] <= key;
                        r_st    <= ciphertext;
                        r_rnd   <= 4'd1;
                    end
                end
                StKeyExp: begin
                    r_rk[r_rnd] <= w_rk_next;
                    if (r_rnd != 4'd10) r_rnd <= r_rnd + 4'd1;
                end
                StInitAk: begin
                    r_st  <= r_st ^ r_rk[10];
                    r_rnd <= 4'd9;
                end
                StRound: begin
                    r_st  <= inv_mix_columns(w_sub ^ r_rk[r_rnd]);
                    r_rnd <= r_rnd - 4'd1;
                end
                StFinal: begin
                    r_st <= w_sub ^ r_rk[0];
                    r_pt <= w_sub ^ r_rk[0];
                end
                default: ;
            endcase
        end
    end

endmodule
